// File: rtl/axis_gain_sequencer.sv
// Gain sequencer for the stereo AXIS volume path: ramps the gain code one step per
// STEP_FRAMES stereo frames toward the switch target, with click-free mute/unmute.
module axis_gain_sequencer #(
    parameter int unsigned GAIN_WIDTH  = 4,
    parameter int unsigned STEP_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GAIN_WIDTH-1:0] sw_target,
    input  logic                  mute_req,
    input  logic                  tap_valid,
    input  logic                  tap_ready,
    input  logic                  tap_last,
    output logic [GAIN_WIDTH-1:0] gain,
    output logic                  ramping,
    output logic                  muted,
    output logic                  step_pulse
);

    localparam int unsigned       CntWidth = $clog2(STEP_FRAMES + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(STEP_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StRamp, StMuted} state_e;

    state_e                state;
    logic [GAIN_WIDTH-1:0] sw_meta, sw_s;
    logic                  mute_meta, mute_s;
    logic [CntWidth-1:0]   frame_cnt;
    logic [GAIN_WIDTH-1:0] tgt, gain_step;
    logic                  frame_end, step_now;

    // Board switches are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta   <= '0;
            sw_s      <= '0;
            mute_meta <= 1'b0;
            mute_s    <= 1'b0;
        end else begin
            sw_meta   <= sw_target;
            sw_s      <= sw_meta;
            mute_meta <= mute_req;
            mute_s    <= mute_meta;
        end
    end

    assign tgt       = mute_s ? '0 : sw_s;
    assign frame_end = tap_valid & tap_ready & tap_last;
    assign step_now  = frame_end && (frame_cnt == CntLast) && (gain != tgt);

    // Stepping only toward tgt keeps gain inside [0, tgt] or [tgt, max]: no wrap possible.
    assign gain_step = !step_now   ? gain :
                       (gain < tgt) ? gain + GAIN_WIDTH'(1) : gain - GAIN_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            gain       <= '0;
            frame_cnt  <= '0;
            ramping    <= 1'b0;
            muted      <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                StIdle: begin
                    frame_cnt <= '0;
                    // mute_s alone also leaves IDLE so a muted-at-zero request lands in MUTED.
                    if (gain != tgt || mute_s) begin
                        state   <= StRamp;
                        ramping <= 1'b1;
                    end
                end
                StRamp: begin
                    gain       <= gain_step;
                    step_pulse <= step_now;
                    if (gain_step == tgt) begin
                        frame_cnt <= '0;
                        ramping   <= 1'b0;
                        if (mute_s) begin
                            state <= StMuted;
                            muted <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end else if (step_now) begin
                        frame_cnt <= '0;
                    end else if (frame_end) begin
                        frame_cnt <= frame_cnt + CntWidth'(1);
                    end
                end
                StMuted: begin
                    if (!mute_s) begin
                        muted <= 1'b0;
                        if (sw_s != '0) begin
                            state   <= StRamp;
                            ramping <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: begin
                    state   <= StIdle;
                    ramping <= 1'b0;
                    muted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_gain_sequencer.sv
// Bench for axis_gain_sequencer: frame-level gain model checked every cycle, plus
// directed scenarios with hand-computed gain/flag expectations.
module tb_axis_gain_sequencer;

    localparam int unsigned GW = 4;
    localparam int          SF = 2;
    localparam int          MIdle = 0, MRamp = 1, MMuted = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [GW-1:0] sw_target = '0;
    logic          mute_req = 1'b0;
    logic          tap_valid = 1'b0, tap_ready = 1'b0, tap_last = 1'b0;
    logic [GW-1:0] gain;
    logic          ramping, muted, step_pulse;

    int vectors = 0, miscompares = 0, pulses = 0, muted_cycles = 0;

    always #5 clk = ~clk;

    axis_gain_sequencer #(
        .GAIN_WIDTH (GW),
        .STEP_FRAMES(SF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_target (sw_target),
        .mute_req  (mute_req),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_last  (tap_last),
        .gain      (gain),
        .ramping   (ramping),
        .muted     (muted),
        .step_pulse(step_pulse)
    );

    // Model: gain as an integer, frames still owed before the next step, and a mode code.
    logic [GW-1:0] m_sw1, m_sw2;
    logic          m_mu1, m_mu2, m_pulse, n_pulse, m_fe;
    int            m_gain, m_left, m_mode, n_gain, n_left, n_mode, m_tgt;

    always_comb begin
        m_tgt   = m_mu2 ? 0 : int'(m_sw2);
        m_fe    = tap_valid & tap_ready & tap_last;
        n_gain  = m_gain;
        n_left  = m_left;
        n_mode  = m_mode;
        n_pulse = 1'b0;
        case (m_mode)
            MIdle: begin
                n_left = SF;
                if (m_gain != m_tgt || m_mu2) n_mode = MRamp;
            end
            MRamp: begin
                if (m_fe && m_gain != m_tgt && m_left == 1) begin
                    n_gain  = (m_gain < m_tgt) ? m_gain + 1 : m_gain - 1;
                    n_left  = SF;
                    n_pulse = 1'b1;
                end else if (m_fe) begin
                    n_left = m_left - 1;
                end
                if (n_gain == m_tgt) begin
                    n_mode = m_mu2 ? MMuted : MIdle;
                    n_left = SF;
                end
            end
            default: if (!m_mu2) n_mode = (m_sw2 != '0) ? MRamp : MIdle;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sw1 <= '0; m_sw2 <= '0; m_mu1 <= 1'b0; m_mu2 <= 1'b0;
            m_gain <= 0; m_left <= SF; m_mode <= MIdle; m_pulse <= 1'b0;
        end else begin
            m_sw1 <= sw_target; m_sw2 <= m_sw1; m_mu1 <= mute_req; m_mu2 <= m_mu1;
            m_gain <= n_gain; m_left <= n_left; m_mode <= n_mode; m_pulse <= n_pulse;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        vectors++;
        if (int'(gain) != m_gain || ramping != (m_mode == MRamp) ||
            muted != (m_mode == MMuted) || step_pulse != m_pulse) begin
            miscompares++;
            $display("FAIL cycle t=%0t: got gain=%0d ramping=%0b muted=%0b step=%0b, model gain=%0d ramping=%0b muted=%0b step=%0b",
                     $time, gain, ramping, muted, step_pulse, m_gain, m_mode == MRamp,
                     m_mode == MMuted, m_pulse);
        end
        if (step_pulse) pulses++;
        if (muted) muted_cycles++;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic r, input logic l);
        @(negedge clk);
        tap_valid = v; tap_ready = r; tap_last = l;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            beat(1'b1, 1'b1, 1'b0);
            beat(1'b1, 1'b1, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frames_until(input int g, input int limit);
        int n = 0;
        while (int'(gain) != g && n < limit) begin
            frames(1);
            n++;
        end
        check($sformatf("reach_gain_%0d", g), int'(gain), g);
    endtask

    initial begin
        int p0, mc0;
        // 1: power-on fade-in to 15
        sw_target = 4'hF;
        idle(3);
        @(negedge clk) rst_n = 1'b1;
        check("reset_gain", int'(gain), 0);
        check("reset_ramping", int'(ramping), 0);
        p0 = pulses;
        frames(5); idle(1);
        check("fade_in_after_5_frames", int'(gain), 2);
        frames(35); idle(2);
        check("fade_in_gain", int'(gain), 15);
        check("fade_in_ramping", int'(ramping), 0);
        check("fade_in_pulses", pulses - p0, 15);

        // 2: mute fades to 0 and holds
        p0 = pulses;
        mute_req = 1'b1;
        frames(40); idle(2);
        check("mute_gain", int'(gain), 0);
        check("mute_muted", int'(muted), 1);
        check("mute_pulses", pulses - p0, 15);

        // 3: unmute, then reverse a fade-out at gain 8
        mute_req = 1'b0;
        frames(40); idle(2);
        check("unmute_gain", int'(gain), 15);
        check("unmute_muted", int'(muted), 0);
        mute_req = 1'b1;
        mc0 = muted_cycles;
        frames_until(8, 60);
        mute_req = 1'b0;
        frames(40); idle(2);
        check("reverse_gain", int'(gain), 15);
        check("reverse_never_muted", muted_cycles - mc0, 0);

        // 4: stalled stream freezes the ramp
        sw_target = 4'd6;
        frames(40); idle(2);
        check("settle_6", int'(gain), 6);
        beat(1'b1, 1'b0, 1'b0);
        sw_target = 4'd9;
        for (int i = 0; i < 12; i++) beat(1'b1, 1'b0, 1'(i % 2));
        check("stall_gain", int'(gain), 6);
        check("stall_ramping", int'(ramping), 1);
        frames(5); idle(2);
        check("unstall_5_frames", int'(gain), 8);
        frames(1); idle(2);
        check("unstall_6_frames", int'(gain), 9);
        check("unstall_ramping", int'(ramping), 0);

        // 5: only valid&ready&last beats count
        sw_target = 4'd11;
        idle(4);
        check("t5_ramping", int'(ramping), 1);
        p0 = pulses;
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b0, 1'b1, 1'b1);
        check("t5_one_counted", int'(gain), 9);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        idle(1);
        check("t5_two_counted", int'(gain), 10);
        check("t5_pulses", pulses - p0, 1);
        frames(4); idle(2);
        check("t5_final", int'(gain), 11);

        // 6: async reset mid-ramp, then fade-in restarts from 0
        sw_target = 4'd2;
        frames_until(7, 40);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_gain", int'(gain), 0);
        check("async_reset_ramping", int'(ramping), 0);
        idle(2);
        @(negedge clk) rst_n = 1'b1;
        frames(3); idle(1);
        check("restart_first_step", int'(gain), 1);
        frames(4); idle(2);
        check("restart_final", int'(gain), 2);
        check("restart_ramping", int'(ramping), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
